// File: rtl/draw_layer_arbiter.sv
// draw_layer_arbiter
// Four-layer pixel arbiter for a raster pipeline. Every pixel clock it picks
// the highest-priority drawable layer (0 > 1 > 2 > 3 > background), registers
// the winning RGB332 pixel and its source index, and accumulates pairwise
// layer overlaps over a frame. The overlap set is published at every
// startOfFrame together with a one-cycle collisionValid pulse.
//
// Optional feature: define DRAW_ARB_BLINK_EN to build a frame counter that
// hides layer 1 for 2^BLINK_LOG2 frames out of every 2^(BLINK_LOG2+1) while
// blinkLayer1 is high. Without the macro no counter exists and blinkLayer1 is
// ignored.
//
// Timing contract: all outputs are registered. RGBOut/activeLayer show the
// result for the inputs of the previous clock. startOfFrame is a one-cycle
// strobe on the first pixel of a frame; there is no handshake, every cycle
// carries exactly one pixel.
module draw_layer_arbiter #(
    parameter logic [7:0] TRANSPARENT_COLOR = 8'hFF,
    parameter int         BLINK_LOG2        = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [3:0] layerEnable,
    input  logic [3:0] drawReq,
    input  logic [7:0] layerRGB0,
    input  logic [7:0] layerRGB1,
    input  logic [7:0] layerRGB2,
    input  logic [7:0] layerRGB3,
    input  logic [7:0] BG_RGB,
    input  logic       blinkLayer1,
    output logic [7:0] RGBOut,
    output logic [2:0] activeLayer,
    output logic [5:0] collisionFlags,
    output logic       collisionValid
);

    // Source index reported when no layer wins.
    localparam logic [2:0] LP_SRC_BG = 3'd4;

    // ------------------------------------------------------------------
    // Frame-synchronous layer enables
    // ------------------------------------------------------------------
    logic [3:0] r_en_latched;
    logic [3:0] w_en_eff;

    // Enables are captured only at the frame boundary so mid-frame changes
    // cannot tear an object.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_en_latched <= 4'b1111;
        end else if (startOfFrame) begin
            r_en_latched <= layerEnable;
        end
    end

    // The boundary pixel already belongs to the new frame, so it uses the
    // enables being latched on that same cycle.
    always_comb begin
        w_en_eff = r_en_latched;
        if (startOfFrame) begin
            w_en_eff = layerEnable;
        end
    end

    // ------------------------------------------------------------------
    // Per-layer validity (blink-independent, feeds collision detection)
    // ------------------------------------------------------------------
    logic [3:0] w_layer_valid;

    // A layer is valid when it requests the pixel, is enabled for this frame
    // and its colour is not the transparent key.
    always_comb begin
        w_layer_valid[0] = drawReq[0] & w_en_eff[0] & (layerRGB0 != TRANSPARENT_COLOR);
        w_layer_valid[1] = drawReq[1] & w_en_eff[1] & (layerRGB1 != TRANSPARENT_COLOR);
        w_layer_valid[2] = drawReq[2] & w_en_eff[2] & (layerRGB2 != TRANSPARENT_COLOR);
        w_layer_valid[3] = drawReq[3] & w_en_eff[3] & (layerRGB3 != TRANSPARENT_COLOR);
    end

    // ------------------------------------------------------------------
    // Layer-1 blink control
    // ------------------------------------------------------------------
    logic w_hide_layer1;

`ifdef DRAW_ARB_BLINK_EN
    localparam int LP_CNT_W = BLINK_LOG2 + 1;

    logic [LP_CNT_W-1:0] r_frame_cnt;
    logic                r_blink_msb;
    logic                w_blink_msb_eff;

    // Frame counter wraps naturally; its MSB is sampled alongside the
    // enables so the blink phase is constant across a frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frame_cnt <= '0;
            r_blink_msb <= 1'b0;
        end else if (startOfFrame) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_blink_msb <= r_frame_cnt[LP_CNT_W-1];
        end
    end

    // Like the enables, the boundary pixel uses the phase being sampled now.
    always_comb begin
        w_blink_msb_eff = r_blink_msb;
        if (startOfFrame) begin
            w_blink_msb_eff = r_frame_cnt[LP_CNT_W-1];
        end
        w_hide_layer1 = blinkLayer1 & w_blink_msb_eff;
    end
`else
    logic w_unused_blink;

    assign w_hide_layer1  = 1'b0;
    assign w_unused_blink = blinkLayer1 ^ BLINK_LOG2[0];
`endif

    // ------------------------------------------------------------------
    // Pixel mux
    // ------------------------------------------------------------------
    logic [3:0] w_mux_valid;
    logic [7:0] w_rgb_sel;
    logic [2:0] w_src_sel;

    // Fixed-priority selection; blinking only removes layer 1 from the mux,
    // never from collision detection.
    always_comb begin
        w_mux_valid    = w_layer_valid;
        w_mux_valid[1] = w_layer_valid[1] & ~w_hide_layer1;
        w_rgb_sel      = BG_RGB;
        w_src_sel      = LP_SRC_BG;
        if (w_mux_valid[0]) begin
            w_rgb_sel = layerRGB0;
            w_src_sel = 3'd0;
        end else if (w_mux_valid[1]) begin
            w_rgb_sel = layerRGB1;
            w_src_sel = 3'd1;
        end else if (w_mux_valid[2]) begin
            w_rgb_sel = layerRGB2;
            w_src_sel = 3'd2;
        end else if (w_mux_valid[3]) begin
            w_rgb_sel = layerRGB3;
            w_src_sel = 3'd3;
        end
    end

    logic [7:0] r_rgb_out;
    logic [2:0] r_active_layer;

    // One register stage between inputs and the pixel outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rgb_out      <= 8'h00;
            r_active_layer <= LP_SRC_BG;
        end else begin
            r_rgb_out      <= w_rgb_sel;
            r_active_layer <= w_src_sel;
        end
    end

    // ------------------------------------------------------------------
    // Collision detection
    // ------------------------------------------------------------------
    logic [5:0] w_overlap;
    logic [5:0] r_coll_acc;
    logic [5:0] r_coll_flags;
    logic       r_coll_valid;

    // Pairwise overlaps of the current pixel, bit order
    // (0,1) (0,2) (0,3) (1,2) (1,3) (2,3).
    always_comb begin
        w_overlap[0] = w_layer_valid[0] & w_layer_valid[1];
        w_overlap[1] = w_layer_valid[0] & w_layer_valid[2];
        w_overlap[2] = w_layer_valid[0] & w_layer_valid[3];
        w_overlap[3] = w_layer_valid[1] & w_layer_valid[2];
        w_overlap[4] = w_layer_valid[1] & w_layer_valid[3];
        w_overlap[5] = w_layer_valid[2] & w_layer_valid[3];
    end

    // Sticky accumulator; at the frame boundary the finished frame is
    // published and the accumulator restarts with the boundary pixel, which
    // belongs to the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_coll_acc   <= 6'b0;
            r_coll_flags <= 6'b0;
            r_coll_valid <= 1'b0;
        end else if (startOfFrame) begin
            r_coll_acc   <= w_overlap;
            r_coll_flags <= r_coll_acc;
            r_coll_valid <= 1'b1;
        end else begin
            r_coll_acc   <= r_coll_acc | w_overlap;
            r_coll_valid <= 1'b0;
        end
    end

    assign RGBOut         = r_rgb_out;
    assign activeLayer    = r_active_layer;
    assign collisionFlags = r_coll_flags;
    assign collisionValid = r_coll_valid;

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Bench for draw_layer_arbiter: directed scenarios followed by randomized
// frames, every cycle compared against a frame-level reference model.
module tb_draw_layer_arbiter;

  localparam logic [7:0] TRANSP = 8'hFF;
  localparam int         BLOG   = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       startOfFrame = 1'b0;
  logic [3:0] layerEnable = 4'hF;
  logic [3:0] drawReq = 4'h0;
  logic [7:0] layerRGB0 = 8'h00;
  logic [7:0] layerRGB1 = 8'h00;
  logic [7:0] layerRGB2 = 8'h00;
  logic [7:0] layerRGB3 = 8'h00;
  logic [7:0] BG_RGB = 8'h00;
  logic       blinkLayer1 = 1'b0;
  logic [7:0] RGBOut;
  logic [2:0] activeLayer;
  logic [5:0] collisionFlags;
  logic       collisionValid;

  always #5 clk = ~clk;

  draw_layer_arbiter #(
    .TRANSPARENT_COLOR(TRANSP),
    .BLINK_LOG2(BLOG)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .layerEnable(layerEnable),
    .drawReq(drawReq),
    .layerRGB0(layerRGB0),
    .layerRGB1(layerRGB1),
    .layerRGB2(layerRGB2),
    .layerRGB3(layerRGB3),
    .BG_RGB(BG_RGB),
    .blinkLayer1(blinkLayer1),
    .RGBOut(RGBOut),
    .activeLayer(activeLayer),
    .collisionFlags(collisionFlags),
    .collisionValid(collisionValid)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_en;
  int         m_sofs;
  logic [5:0] m_acc;
  logic [5:0] m_flags;

  task automatic model_reset();
    m_en    = 4'hF;
    m_sofs  = 0;
    m_acc   = 6'b0;
    m_flags = 6'b0;
    exp_q.delete();
  endtask

  // Expected outputs after the coming clock edge for the inputs now applied.
  task automatic model_cycle(output logic [17:0] e);
    logic [7:0] rgb[4];
    logic [3:0] vis;
    logic       hidden;
    logic [7:0] o_rgb;
    logic [2:0] o_src;
    logic [5:0] ov;
    logic       cv;
    int         k;
    int         frame;
    rgb[0] = layerRGB0; rgb[1] = layerRGB1; rgb[2] = layerRGB2; rgb[3] = layerRGB3;
    if (startOfFrame) begin
      m_en = layerEnable;
      m_sofs++;
    end
    hidden = 1'b0;
    frame  = 0;
`ifdef DRAW_ARB_BLINK_EN
    if (m_sofs > 0) begin
      frame  = (m_sofs - 1) % (2 ** (BLOG + 1));
      hidden = blinkLayer1 && (frame >= 2 ** BLOG);
    end
`endif
    for (int i = 0; i < 4; i++) vis[i] = drawReq[i] && m_en[i] && (rgb[i] != TRANSP);
    o_rgb = BG_RGB;
    o_src = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (vis[i] && !(i == 1 && hidden)) begin
        o_rgb = rgb[i];
        o_src = 3'(i);
      end
    end
    ov = 6'b0;
    k  = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        ov[k] = vis[i] & vis[j];
        k++;
      end
    end
    if (startOfFrame) begin
      m_flags = m_acc;
      m_acc   = ov;
      cv      = 1'b1;
    end else begin
      m_acc = m_acc | ov;
      cv    = 1'b0;
    end
    e = {o_rgb, o_src, m_flags, cv};
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [17:0] e;
    model_cycle(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rgb_out", RGBOut, e[17:10]);
    check("active_layer", activeLayer, e[9:7]);
    check("coll_flags", collisionFlags, e[6:1]);
    check("coll_valid", collisionValid, e[0]);
  endtask

  task automatic set_pix(input logic [3:0] req, input logic [7:0] r0, input logic [7:0] r1,
                         input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] bg);
    drawReq = req;
    layerRGB0 = r0; layerRGB1 = r1; layerRGB2 = r2; layerRGB3 = r3;
    BG_RGB = bg;
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic apply_reset();
    #2;
    resetN = 1'b0;
    #1;
    check("rst_rgb", RGBOut, 8'h00);
    check("rst_layer", activeLayer, 3'd4);
    check("rst_flags", collisionFlags, 6'b0);
    check("rst_valid", collisionValid, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_layer", activeLayer, 3'd4);
    resetN = 1'b1;
    startOfFrame = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    apply_reset();

    // Priority: layers 1 and 3 drawing, layer 1 wins (boundary pixel).
    startOfFrame = 1'b1; layerEnable = 4'hF;
    set_pix(4'b1010, 8'h11, 8'h1C, 8'h22, 8'hE0, 8'h05);
    tick();
    check("prio_rgb", RGBOut, 8'h1C);
    check("prio_layer", activeLayer, 3'd1);
    startOfFrame = 1'b0;

    // Transparency: layer 0 requests with the key colour -> background.
    set_pix(4'b0001, 8'hFF, 8'h1C, 8'h22, 8'hE0, 8'hB7);
    tick();
    check("transp_rgb", RGBOut, 8'hB7);
    check("transp_layer", activeLayer, 3'd4);
    set_pix(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10);
    tick();
    tick();

    // Collision report of the frame above: only pair (1,3).
    startOfFrame = 1'b1;
    tick();
    check("coll_13_flags", collisionFlags, 6'b010000);
    check("coll_13_valid", collisionValid, 1'b1);
    startOfFrame = 1'b0;
    tick();
    check("coll_pulse_end", collisionValid, 1'b0);
    tick();
    startOfFrame = 1'b1;
    tick();
    check("coll_clear_flags", collisionFlags, 6'b0);
    startOfFrame = 1'b0;

    // Enable latching: dropping layer 0 mid-frame has no effect yet.
    startOfFrame = 1'b1; layerEnable = 4'hF;
    set_pix(4'b0001, 8'h42, 8'h00, 8'h00, 8'h00, 8'h33);
    tick();
    startOfFrame = 1'b0;
    layerEnable = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_hold_rgb", RGBOut, 8'h42);
    end
    startOfFrame = 1'b1;
    tick();
    check("en_new_rgb", RGBOut, 8'h33);
    check("en_new_layer", activeLayer, 3'd4);
    startOfFrame = 1'b0;
    layerEnable = 4'hF;

    // Reset mid-frame after an overlap discards it.
    startOfFrame = 1'b1;
    set_pix(4'b0011, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00);
    tick();
    startOfFrame = 1'b0;
    tick();
    apply_reset();
    set_pix(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_pulse", collisionValid, 1'b0);
    end
    startOfFrame = 1'b1;
    tick();
    check("post_rst_flags", collisionFlags, 6'b0);
    check("post_rst_pulse", collisionValid, 1'b1);
    startOfFrame = 1'b0;

    // Blink: layers 1 and 2 overlap every frame, layer 1 blinking.
    apply_reset();
    blinkLayer1 = 1'b1;
    layerEnable = 4'hF;
    set_pix(4'b0110, 8'h00, 8'h1C, 8'h03, 8'h00, 8'h00);
    for (int f = 0; f < 18; f++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      if (f == 0) check("blink_f0_layer", activeLayer, 3'd1);
      if (f == 9) check("blink_hidden_coll", collisionFlags, 6'b001000);
      tick();
      if (f == 8) begin
`ifdef DRAW_ARB_BLINK_EN
        check("blink_f8_layer", activeLayer, 3'd2);
`else
        check("blink_f8_layer", activeLayer, 3'd1);
`endif
      end
      tick();
    end
    blinkLayer1 = 1'b0;

    // Randomized frames.
    for (int f = 0; f < 160; f++) begin
      int len;
      len = $urandom_range(2, 10);
      blinkLayer1 = 1'($urandom_range(0, 1));
      for (int c = 0; c < len; c++) begin
        logic [3:0] req;
        logic [7:0] r[4];
        startOfFrame = (c == 0);
        layerEnable = 4'($urandom_range(0, 15));
        for (int b = 0; b < 4; b++) begin
          req[b] = ($urandom_range(0, 9) < 3);
          r[b] = ($urandom_range(0, 4) == 0) ? TRANSP : 8'($urandom_range(0, 254));
        end
        set_pix(req, r[0], r[1], r[2], r[3], 8'($urandom_range(0, 255)));
        tick();
        if (c == 1 && $urandom_range(0, 39) == 0) apply_reset();
      end
    end
    startOfFrame = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
